can_tx_fifo_param: RTL

Parametrised transmit-frame buffer for the CAN core. It sits between the host/IP register interface and the CAN transmit engine.
- Frames are held in first-word fall-through order.
- The head frame stays resident until the transmit engine confirms successful transmission, so a frame survives lost arbitration or an error frame and is re-sent.
- Adds exact full/empty detection, an almost-full threshold, flush, and sticky overflow/underflow error flags.

---
 rtl/can_pkg.sv | 22 ++
 rtl/can_fifo_mem.sv | 26 ++
 rtl/can_tx_fifo_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN constants: frame word geometry, TX buffer sizing and field
// positions inside a frame word.
package can_pkg;

  // Frame word: ID + control + 64-bit payload
  localparam int CAN_FRAME_W       = 128;
  localparam int CAN_TXFIFO_DEPTH  = 64;
  localparam int CAN_TXFIFO_AFULL  = 60;

  // Field layout within a frame word (LSB positions and widths)
  localparam int CAN_PAYLOAD_LSB   = 0;
  localparam int CAN_PAYLOAD_W     = 64;
  localparam int CAN_DLC_LSB       = 64;
  localparam int CAN_DLC_W         = 4;
  localparam int CAN_RTR_BIT       = 68;
  localparam int CAN_IDE_BIT       = 69;
  localparam int CAN_ID_LSB        = 70;
  localparam int CAN_ID_W          = 29;

  typedef logic [CAN_FRAME_W-1:0] can_frame_t;

endpackage

// File: rtl/can_fifo_mem.sv
// Simple-dual-port frame storage: synchronous write, asynchronous read, so
// the head frame is available in the same cycle the read pointer moves.
module can_fifo_mem #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store an accepted frame at the write address
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/can_tx_fifo_param.sv
// First-word fall-through transmit frame buffer. The head frame stays
// resident until the transmit engine reports success via tx_done, so frames
// that lose arbitration or hit an error frame are simply re-sent.
module can_tx_fifo_param
  import can_pkg::*;
#(
  parameter int WIDTH        = CAN_FRAME_W,
  parameter int DEPTH        = CAN_TXFIFO_DEPTH,
  parameter int AFULL_THRESH = CAN_TXFIFO_AFULL
) (
  input  logic                   sys_clk,
  input  logic                   IP2Can_reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   almost_full,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err,
  output logic                   udf_err,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // MSB is the wrap bit

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             pop, wr_accept, ovf_set, udf_set, ptr_empty;
  logic [WIDTH-1:0] mem_rdata;

  // Occupancy flags come straight from the registered count
  assign full        = (count_q == PW'(DEPTH));
  assign almost_full = (count_q >= PW'(AFULL_THRESH));
  assign rd_valid    = (count_q != '0);
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

  // A write at full is still taken when the head leaves in the same cycle
  assign pop       = tx_done & ~flush & rd_valid;
  assign wr_accept = wr_en & ~flush & (~full | pop);
  assign ovf_set   = wr_en & ~flush & ~wr_accept;
  assign udf_set   = tx_done & ~flush & ~rd_valid;

  // Head frame is forced to zero whenever nothing is stored
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign rd_data   = ptr_empty ? '0 : mem_rdata;

  can_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (sys_clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Clear first so an error in the same cycle still sets its flag
    ovf_d    = (err_clr ? 1'b0 : ovf_q) | ovf_set;
    udf_d    = (err_clr ? 1'b0 : udf_q) | udf_set;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (wr_accept && !pop) begin
        count_d = count_q + PW'(1);
      end else if (!wr_accept && pop) begin
        count_d = count_q - PW'(1);
      end
    end
  end

  // Control state registers, cleared asynchronously by the IP reset
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n) begin
    if (!IP2Can_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule
